// File: rtl/sevenseg_scan_if.sv
// rtl/sevenseg_scan_if.sv - Display driver bus: hex value, load, dp and brightness in; segment and digit pins out
interface sevenseg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_i;
  logic                    load_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [3:0]              bright_i;
  logic [6:0]              seg_o;
  logic [6:0]              segn_o;
  logic                    dp_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic [NUM_DIGITS-1:0]   ann_o;

  modport master (
    output value_i, load_i, dp_i, bright_i,
    input  seg_o, segn_o, dp_o, an_o, ann_o
  );

  modport slave (
    input  value_i, load_i, dp_i, bright_i,
    output seg_o, segn_o, dp_o, an_o, ann_o
  );
endinterface

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - Multiplexed seven-segment driver with PWM dimming and tear-free frame updates
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module sevenseg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  sevenseg_scan_if.slave  bus
);
  localparam int SCW = $clog2(CLK_DIV);
  localparam int DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DV  = 4 * NUM_DIGITS;

  logic [SCW-1:0]        r_scan_cnt;
  logic [DW-1:0]         r_digit_idx;
  logic [3:0]            r_pwm_cnt;
  logic [DV-1:0]         r_pend_val;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic [DV-1:0]         r_disp_val;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;

  logic       w_slot_end;
  logic       w_frame_end;
  logic       w_on;
  logic [3:0] w_nibble;
  logic [6:0] w_glyph;
  logic       w_dp;
  logic       w_blank;

  always_comb begin
    w_slot_end  = (r_scan_cnt == SCW'(CLK_DIV - 1));
    w_frame_end = w_slot_end && (r_digit_idx == DW'(NUM_DIGITS - 1));
    // Slot position 0 is always dark so the old digit never ghosts onto the new enable.
    w_on        = (r_scan_cnt != '0) &&
                  ((bus.bright_i == 4'hF) || (r_pwm_cnt < bus.bright_i));
    w_nibble    = r_disp_val[{r_digit_idx, 2'b00} +: 4];
    w_dp        = r_disp_dp[r_digit_idx];
    case (w_nibble)
      4'h0:    w_glyph = 7'h3F;
      4'h1:    w_glyph = 7'h06;
      4'h2:    w_glyph = 7'h5B;
      4'h3:    w_glyph = 7'h4F;
      4'h4:    w_glyph = 7'h66;
      4'h5:    w_glyph = 7'h6D;
      4'h6:    w_glyph = 7'h7D;
      4'h7:    w_glyph = 7'h07;
      4'h8:    w_glyph = 7'h7F;
      4'h9:    w_glyph = 7'h6F;
      4'hA:    w_glyph = 7'h77;
      4'hB:    w_glyph = 7'h7C;
      4'hC:    w_glyph = 7'h39;
      4'hD:    w_glyph = 7'h5E;
      4'hE:    w_glyph = 7'h79;
      default: w_glyph = 7'h71;
    endcase
  end

`ifdef SEVENSEG_LZB_EN
  logic [NUM_DIGITS-1:0] w_lz_mask;

  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic v_zero_above;
    v_zero_above = 1'b1;
    w_lz_mask    = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      v_zero_above = v_zero_above && (r_disp_val[4*k +: 4] == 4'h0);
      w_lz_mask[k] = v_zero_above;
    end
  end

  assign w_blank = w_lz_mask[r_digit_idx];
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= '0;
      r_pwm_cnt   <= '0;
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_disp_val  <= '0;
      r_disp_dp   <= '0;
      r_seg       <= '0;
      r_dp        <= 1'b0;
      r_an        <= '0;
    end else begin
      r_scan_cnt <= w_slot_end ? '0 : r_scan_cnt + SCW'(1);
      if (w_slot_end) begin
        r_digit_idx <= (r_digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : r_digit_idx + DW'(1);
      end
      r_pwm_cnt <= r_pwm_cnt + 4'd1;

      if (bus.load_i) begin
        r_pend_val <= bus.value_i;
        r_pend_dp  <= bus.dp_i;
      end
      // A load landing on the boundary bypasses pending so it is shown in the very next frame.
      if (w_frame_end) begin
        r_disp_val <= bus.load_i ? bus.value_i : r_pend_val;
        r_disp_dp  <= bus.load_i ? bus.dp_i    : r_pend_dp;
      end

      r_an  <= w_on ? (NUM_DIGITS'(1) << r_digit_idx) : '0;
      r_seg <= (w_on && !w_blank) ? w_glyph : 7'h00;
      r_dp  <= w_on && w_dp;
    end
  end

  assign bus.seg_o  = r_seg;
  assign bus.segn_o = ~r_seg;
  assign bus.dp_o   = r_dp;
  assign bus.an_o   = r_an;
  assign bus.ann_o  = ~r_an;
endmodule
